// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands DIGIT bits
// per clock, starting at the most significant digit. Signed compares are turned
// into unsigned ones by flipping the sign bit of both operands at capture.
// Results (gt/eq/lt) are registered and one-hot from the done cycle onward.
//
// Timing: the top digit is compared on the accepting edge itself, straight from
// the (sign-adjusted) a/b inputs. Each following SCAN edge compares one more
// digit, so an operation that examines N digits raises done in the N-th cycle
// after acceptance and keeps busy high for exactly those N cycles.

module seq_magnitude_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    // The top digit is consumed on the accepting edge, so SCAN starts one
    // digit further down.
    localparam int IDX_START = (NDIG > 1) ? NDIG - 2 : 0;

    // Parameter sanity: refuse to elaborate an inconsistent configuration.
    if (WIDTH < 2) begin : g_bad_width
        $error("seq_magnitude_comparator: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Captured operands, kept left-aligned: the digit under test is always the
    // top DIGIT bits, and each SCAN edge shifts the next digit into place.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;

    // First differing digit seen so far (only one of the two can be set).
    logic diff_gt;
    logic diff_lt;

    logic [WIDTH-1:0] sign_flip;
    logic [WIDTH-1:0] adj_a;
    logic [WIDTH-1:0] adj_b;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_gt;
    logic             dig_lt;
    logic             res_gt;
    logic             res_lt;
    logic             last_digit;
    logic             finish;
    logic             accept;

    // Sign-bit inversion maps two's-complement order onto unsigned order.
    assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
    assign adj_a     = a ^ sign_flip;
    assign adj_b     = b ^ sign_flip;

    assign accept = (state == S_IDLE) && start;

    // Select the digit under test, compare it, and merge with any earlier difference.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        dig_a      = adj_a[WIDTH-1 -: DIGIT];
        dig_b      = adj_b[WIDTH-1 -: DIGIT];
        last_digit = (NDIG == 1);
        if (state == S_SCAN) begin
            dig_a      = a_q[WIDTH-1 -: DIGIT];
            dig_b      = b_q[WIDTH-1 -: DIGIT];
            last_digit = (idx == '0);
        end

        dig_gt = (dig_a > dig_b);
        dig_lt = (dig_a < dig_b);

        // An earlier difference always wins over the current digit.
        res_gt = dig_gt;
        res_lt = dig_lt;
        if ((state == S_SCAN) && (diff_gt || diff_lt)) begin
            res_gt = diff_gt;
            res_lt = diff_lt;
        end

        finish = last_digit || ((EARLY_EXIT != 0) && (dig_gt || dig_lt));
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> SCAN/DONE on accept, SCAN -> DONE when finished.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = finish ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (finish) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, digit shifting, first-difference tracking, results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            diff_gt <= 1'b0;
            diff_lt <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= adj_a << DIGIT;
                b_q     <= adj_b << DIGIT;
                idx     <= IDX_W'(IDX_START);
                diff_gt <= dig_gt;
                diff_lt <= dig_lt;
                gt      <= 1'b0;
                eq      <= 1'b0;
                lt      <= 1'b0;
            end else if (state == S_SCAN) begin
                a_q <= a_q << DIGIT;
                b_q <= b_q << DIGIT;
                if (idx != '0) begin
                    idx <= idx - IDX_W'(1);
                end
                // Only the first difference counts; lower digits cannot change it.
                if (!(diff_gt || diff_lt)) begin
                    diff_gt <= dig_gt;
                    diff_lt <= dig_lt;
                end
            end

            // Publish the one-hot result on the edge that enters DONE; this
            // overrides the clear done on a single-digit accept.
            if (finish && (accept || (state == S_SCAN))) begin
                gt <= res_gt;
                lt <= res_lt;
                eq <= ~(res_gt | res_lt);
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator
// Directed bench for seq_magnitude_comparator. Three instances share operands
// and reset: [0] WIDTH=16/DIGIT=4 early exit, [1] WIDTH=16/DIGIT=4 full scan,
// [2] WIDTH=16/DIGIT=16. A vector table covers latency and result per
// operation; hand sequences cover start-held, operand changes and reset abort.

module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic [2:0]  start_w;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [2:0]  gt_w;
    logic [2:0]  eq_w;
    logic [2:0]  lt_w;

    int checks;
    int errors;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        int          exp_n;
        logic [2:0]  exp_res;  // {gt, eq, lt}
        string       name;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst(rst), .start(start_w[0]), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy_w[0]), .done(done_w[0]),
        .gt(gt_w[0]), .eq(eq_w[0]), .lt(lt_w[0])
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .start(start_w[1]), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy_w[1]), .done(done_w[1]),
        .gt(gt_w[1]), .eq(eq_w[1]), .lt(lt_w[1])
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(16), .EARLY_EXIT(1)) u_single (
        .clk(clk), .rst(rst), .start(start_w[2]), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy_w[2]), .done(done_w[2]),
        .gt(gt_w[2]), .eq(eq_w[2]), .lt(lt_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] results(input int sel);
        return {gt_w[sel], eq_w[sel], lt_w[sel]};
    endfunction

    // Start one operation on instance sel from a negedge and check latency,
    // busy, intermediate clear, final result and the return to IDLE.
    task automatic run_op(input int sel, input logic [15:0] va, input logic [15:0] vb,
                          input logic sm, input int exp_n, input logic [2:0] exp_res,
                          input string name);
        int seen;
        a              = va;
        b              = vb;
        signed_mode    = sm;
        start_w[sel]   = 1'b1;
        @(negedge clk);
        start_w[sel]   = 1'b0;
        // Cycle 1 after acceptance.
        check({name, "_busy1"}, 32'(busy_w[sel]), 32'd1);
        if (exp_n > 1) begin
            check({name, "_clear"}, 32'(results(sel)), 32'd0);
        end
        seen = 0;
        for (int c = 1; c <= 12 && seen == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (done_w[sel]) seen = c;
        end
        check({name, "_latency"}, 32'(seen), 32'(exp_n));
        check({name, "_result"}, 32'(results(sel)), 32'(exp_res));
        @(negedge clk);
        check({name, "_idle"}, 32'({busy_w[sel], done_w[sel]}), 32'd0);
        check({name, "_hold"}, 32'(results(sel)), 32'(exp_res));
    endtask

    initial begin
        int dones;
        int idles;
        int seen;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start_w     = '0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;

        vecs[0]  = '{0, 16'h1234, 16'h1234, 1'b0, 4, 3'b010, "eq_1234"};
        vecs[1]  = '{0, 16'h8000, 16'h7FFF, 1'b0, 1, 3'b100, "u_top_gt"};
        vecs[2]  = '{0, 16'h8000, 16'h7FFF, 1'b1, 1, 3'b001, "s_top_lt"};
        vecs[3]  = '{0, 16'h0100, 16'h0010, 1'b0, 2, 3'b100, "early_d2"};
        vecs[4]  = '{0, 16'h1234, 16'h1235, 1'b0, 4, 3'b001, "early_d4"};
        vecs[5]  = '{1, 16'h8000, 16'h7FFF, 1'b0, 4, 3'b100, "full_gt"};
        vecs[6]  = '{0, 16'hFFFE, 16'hFFFF, 1'b1, 4, 3'b001, "s_neg_lt"};
        vecs[7]  = '{2, 16'hFFFE, 16'hFFFF, 1'b1, 1, 3'b001, "single_neg_lt"};
        vecs[8]  = '{0, 16'h0005, 16'h0003, 1'b0, 4, 3'b100, "low_gt"};
        vecs[9]  = '{1, 16'h0005, 16'h0003, 1'b1, 4, 3'b100, "full_s_gt"};
        vecs[10] = '{2, 16'h8000, 16'h7FFF, 1'b1, 1, 3'b001, "single_s_lt"};
        vecs[11] = '{0, 16'h7FFF, 16'h8000, 1'b1, 1, 3'b100, "s_pos_gt"};
        vecs[12] = '{1, 16'h1234, 16'h1234, 1'b1, 4, 3'b010, "full_eq"};
        vecs[13] = '{0, 16'hF000, 16'h0FFF, 1'b1, 1, 3'b001, "s_mixed_lt"};

        // Reset state of all instances.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_busy_done_%0d", s), 32'({busy_w[s], done_w[s]}), 32'd0);
            check($sformatf("reset_results_%0d", s), 32'(results(s)), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Table-driven operations.
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sm,
                   vecs[i].exp_n, vecs[i].exp_res, vecs[i].name);
        end

        // Results hold for several idle cycles.
        run_op(0, 16'h1234, 16'h1234, 1'b0, 4, 3'b010, "hold_setup");
        repeat (3) @(negedge clk);
        check("hold_long", 32'(results(0)), 32'b010);

        // Start held high for 20 cycles: accepts only from IDLE.
        a           = 16'h1234;
        b           = 16'h1234;
        signed_mode = 1'b0;
        start_w[0]  = 1'b1;
        dones = 0;
        idles = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done_w[0]) dones++;
            if (!busy_w[0]) idles++;
        end
        start_w[0] = 1'b0;
        check("held_start_dones", 32'(dones), 32'd4);
        check("held_start_idles", 32'(idles), 32'd4);
        check("held_start_eq", 32'(results(0)), 32'b010);
        @(negedge clk);
        check("held_start_stop", 32'(busy_w[0]), 32'd0);

        // Operands change right after acceptance: result uses the captured ones.
        a          = 16'h0100;
        b          = 16'h0010;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        a          = 16'h0000;
        b          = 16'hFFFF;
        start_w[0] = 1'b0;
        seen = 0;
        for (int c = 1; c <= 12 && seen == 0; c++) begin
            @(negedge clk);
            if (done_w[0]) seen = c;
        end
        check("late_change_latency", 32'(seen), 32'd2);
        check("late_change_result", 32'(results(0)), 32'b100);
        @(negedge clk);

        // Reset during the second SCAN cycle aborts without a done pulse.
        a          = 16'h1234;
        b          = 16'h1234;
        start_w[0] = 1'b1;
        @(negedge clk);  // cycle 1 (first SCAN)
        start_w[0] = 1'b0;
        check("abort_busy_before", 32'(busy_w[0]), 32'd1);
        @(negedge clk);  // cycle 2 (second SCAN)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_done", 32'(done_w[0]), 32'd0);
        check("abort_results", 32'(results(0)), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_w[0]) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op(0, 16'h0005, 16'h0003, 1'b0, 4, 3'b100, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
